// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - sequential-PC fetch stage with credit flow control, in-flight PC pairing and instruction buffer
module fetch_queue #(
  parameter int               XLEN     = 64,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       fetch_addr_ready,
  output logic                       fetch_addr_valid,
  output logic [XLEN-1:0]            fetch_addr,
  input  logic                       fetch_data_valid,
  input  logic [31:0]                fetch_data,
  input  logic                       redirect_valid_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  output logic                       inst_valid_o,
  input  logic                       inst_ready_i,
  output logic [XLEN-1:0]            inst_pc_o,
  output logic [31:0]                inst_data_o,
  output logic [$clog2(DEPTH):0]     occupancy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   out_q, out_d, disc_q, disc_d, cnt_q, cnt_d;
  logic [AW-1:0]   pf_wr_q, pf_rd_q, ib_wr_q, ib_rd_q;
  logic [XLEN-1:0] pf_mem [DEPTH];
  logic [XLEN-1:0] ib_pc [DEPTH];
  logic [31:0]     ib_data [DEPTH];

  logic [CW:0] used;
  logic        issue, resp, drop, push, pop;

  // Credits count both outstanding requests and buffered words, so the buffer can never overflow.
  assign used             = {1'b0, out_q} + {1'b0, cnt_q};
  assign fetch_addr_valid = (used < DEPTH_W) && !redirect_valid_i;
  assign fetch_addr       = pc_q;
  assign issue            = fetch_addr_valid && fetch_addr_ready;
  assign resp             = fetch_data_valid && (out_q != '0);
  assign drop             = resp && (disc_q != '0);
  assign push             = resp && !drop && !redirect_valid_i;
  assign inst_valid_o     = (cnt_q != '0) && !redirect_valid_i;
  assign pop              = inst_valid_o && inst_ready_i;
  assign inst_pc_o        = ib_pc[ib_rd_q];
  assign inst_data_o      = ib_data[ib_rd_q];
  assign occupancy_o      = cnt_q;

  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q + CW'(issue) - CW'(resp);
    disc_d = disc_q - CW'(drop);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    if (issue) pc_d = pc_q + XLEN'(4);
    // Every request still outstanding (minus one answered now) becomes stale.
    if (redirect_valid_i) begin
      pc_d   = {redirect_pc_i[XLEN-1:2], 2'b00};
      disc_d = out_q - CW'(resp);
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q    <= RESET_PC;
      out_q   <= '0;
      disc_q  <= '0;
      cnt_q   <= '0;
      pf_wr_q <= '0;
      pf_rd_q <= '0;
      ib_wr_q <= '0;
      ib_rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pf_mem[i]  <= '0;
        ib_pc[i]   <= '0;
        ib_data[i] <= '0;
      end
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      disc_q <= disc_d;
      cnt_q  <= cnt_d;
      if (redirect_valid_i) begin
        pf_wr_q <= '0;
        pf_rd_q <= '0;
        ib_wr_q <= '0;
        ib_rd_q <= '0;
      end else begin
        if (issue) begin
          pf_mem[pf_wr_q] <= pc_q;
          pf_wr_q         <= pf_wr_q + 1'b1;
        end
        if (push) begin
          pf_rd_q          <= pf_rd_q + 1'b1;
          ib_pc[ib_wr_q]   <= pf_mem[pf_rd_q];
          ib_data[ib_wr_q] <= fetch_data;
          ib_wr_q          <= ib_wr_q + 1'b1;
        end
        if (pop) ib_rd_q <= ib_rd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (!(fetch_data_valid && out_q == '0));
      assert (!(push && !pop && cnt_q == DEPTH_C));
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed bench for fetch_queue with a fixed-latency in-order cache model
module tb_fetch_queue;

  logic        clk, rstn;
  logic        far, fav, fdv, rv, iv, ir;
  logic [63:0] fa, rpc, ipc;
  logic [31:0] fd, idata;
  logic [2:0]  occ;

  logic        far2, fav2, fdv2, rv2, iv2, ir2;
  logic [63:0] fa2, rpc2, ipc2;
  logic [31:0] fd2, idata2;
  logic [2:0]  occ2;

  fetch_queue #(.XLEN(64), .DEPTH(4), .RESET_PC(64'h0)) dut (
    .clk(clk), .rstn(rstn),
    .fetch_addr_ready(far), .fetch_addr_valid(fav), .fetch_addr(fa),
    .fetch_data_valid(fdv), .fetch_data(fd),
    .redirect_valid_i(rv), .redirect_pc_i(rpc),
    .inst_valid_o(iv), .inst_ready_i(ir), .inst_pc_o(ipc), .inst_data_o(idata),
    .occupancy_o(occ)
  );

  fetch_queue #(.XLEN(64), .DEPTH(4), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .clk(clk), .rstn(rstn),
    .fetch_addr_ready(far2), .fetch_addr_valid(fav2), .fetch_addr(fa2),
    .fetch_data_valid(fdv2), .fetch_data(fd2),
    .redirect_valid_i(rv2), .redirect_pc_i(rpc2),
    .inst_valid_o(iv2), .inst_ready_i(ir2), .inst_pc_o(ipc2), .inst_data_o(idata2),
    .occupancy_o(occ2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          lat = 1;
  logic [63:0] cq_addr[$];
  int          cq_due[$];
  logic [63:0] iss_q[$];
  logic [63:0] pop_pc[$];
  logic [31:0] pop_data[$];
  int          pop_cyc[$];
  logic        hs_now, pop_now;
  logic [63:0] addr_now, pc_now;
  logic [31:0] data_now;

  function automatic logic [31:0] mkdata(input logic [63:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  task automatic settle();
    if (cq_addr.size() > 0 && cq_due[0] <= cyc) begin
      fdv = 1'b1;
      fd  = mkdata(cq_addr[0]);
    end else begin
      fdv = 1'b0;
      fd  = 32'h0;
    end
    #1;
    hs_now   = rstn && fav && far;
    pop_now  = rstn && iv && ir;
    addr_now = fa;
    pc_now   = ipc;
    data_now = idata;
  endtask

  task automatic clk_edge();
    @(posedge clk);
    if (fdv) begin
      void'(cq_addr.pop_front());
      void'(cq_due.pop_front());
    end
    if (hs_now) begin
      cq_addr.push_back(addr_now);
      cq_due.push_back(cyc + lat);
      iss_q.push_back(addr_now);
    end
    if (pop_now) begin
      pop_pc.push_back(pc_now);
      pop_data.push_back(data_now);
      pop_cyc.push_back(cyc);
    end
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      settle();
      clk_edge();
    end
  endtask

  task automatic clear_logs();
    iss_q.delete();
    pop_pc.delete();
    pop_data.delete();
    pop_cyc.delete();
  endtask

  task automatic do_reset(input int l);
    rstn = 1'b0;
    lat  = l;
    far = 1'b1; rv = 1'b0; rpc = 64'h0; ir = 1'b1;
    cq_addr.delete();
    cq_due.delete();
    run(2);
    rstn = 1'b1;
    cyc  = 0;
    clear_logs();
  endtask

  task automatic test_reset();
    do_reset(1);
    #1;
    n_checks++; if (fav !== 1'b1) begin n_fail++; $display("FAIL reset_fav got %b want 1", fav); end
    n_checks++; if (fa !== 64'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", fa); end
    n_checks++; if (iv !== 1'b0) begin n_fail++; $display("FAIL reset_iv got %b want 0", iv); end
    n_checks++; if (ipc !== 64'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", ipc); end
    n_checks++; if (idata !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", idata); end
    n_checks++; if (occ !== 3'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occ); end
  endtask

  task automatic test_sequential();
    do_reset(1);
    run(8);
    n_checks++; if (iss_q.size() != 8) begin n_fail++; $display("FAIL seq_issue_count got %0d want 8", iss_q.size()); end
    for (int i = 0; i < iss_q.size(); i++) begin
      n_checks++; if (iss_q[i] !== 64'(4*i)) begin n_fail++; $display("FAIL seq_issue[%0d] got %h want %h", i, iss_q[i], 64'(4*i)); end
    end
    n_checks++; if (pop_pc.size() != 6) begin n_fail++; $display("FAIL seq_pop_count got %0d want 6", pop_pc.size()); end
    if (pop_pc.size() > 0) begin
      n_checks++; if (pop_cyc[0] != 2) begin n_fail++; $display("FAIL seq_first_pop_cycle got %0d want 2", pop_cyc[0]); end
    end
    for (int i = 0; i < pop_pc.size(); i++) begin
      n_checks++; if (pop_pc[i] !== 64'(4*i)) begin n_fail++; $display("FAIL seq_pc[%0d] got %h want %h", i, pop_pc[i], 64'(4*i)); end
      n_checks++; if (pop_data[i] !== mkdata(64'(4*i))) begin n_fail++; $display("FAIL seq_data[%0d] got %h want %h", i, pop_data[i], mkdata(64'(4*i))); end
      n_checks++; if (pop_cyc[i] != i + 2) begin n_fail++; $display("FAIL seq_rate[%0d] got cycle %0d want %0d", i, pop_cyc[i], i + 2); end
    end
  endtask

  task automatic test_stall();
    do_reset(1);
    ir = 1'b0;
    run(8);
    n_checks++; if (iss_q.size() != 4) begin n_fail++; $display("FAIL stall_issue_count got %0d want 4", iss_q.size()); end
    n_checks++; if (fav !== 1'b0) begin n_fail++; $display("FAIL stall_fav got %b want 0", fav); end
    n_checks++; if (occ !== 3'd4) begin n_fail++; $display("FAIL stall_occ got %0d want 4", occ); end
    n_checks++; if (pop_pc.size() != 0) begin n_fail++; $display("FAIL stall_no_pop got %0d want 0", pop_pc.size()); end
    ir = 1'b1;
    run(8);
    n_checks++; if (pop_pc.size() < 4) begin n_fail++; $display("FAIL stall_drain_count got %0d want >=4", pop_pc.size()); end
    for (int i = 0; i < 4 && i < pop_pc.size(); i++) begin
      n_checks++; if (pop_pc[i] !== 64'(4*i)) begin n_fail++; $display("FAIL stall_pc[%0d] got %h want %h", i, pop_pc[i], 64'(4*i)); end
      n_checks++; if (pop_data[i] !== mkdata(64'(4*i))) begin n_fail++; $display("FAIL stall_data[%0d] got %h want %h", i, pop_data[i], mkdata(64'(4*i))); end
    end
  endtask

  task automatic test_toggle_ready();
    do_reset(1);
    for (int i = 0; i < 20; i++) begin
      far = (i % 2 == 0);
      run(1);
    end
    far = 1'b1;
    n_checks++; if (iss_q.size() != 10) begin n_fail++; $display("FAIL tog_issue_count got %0d want 10", iss_q.size()); end
    for (int i = 0; i < iss_q.size(); i++) begin
      n_checks++; if (iss_q[i] !== 64'(4*i)) begin n_fail++; $display("FAIL tog_issue[%0d] got %h want %h", i, iss_q[i], 64'(4*i)); end
    end
    n_checks++; if (pop_pc.size() < 9) begin n_fail++; $display("FAIL tog_pop_count got %0d want >=9", pop_pc.size()); end
    for (int i = 0; i < pop_pc.size(); i++) begin
      n_checks++; if (pop_pc[i] !== 64'(4*i)) begin n_fail++; $display("FAIL tog_pc[%0d] got %h want %h", i, pop_pc[i], 64'(4*i)); end
    end
  endtask

  task automatic test_redirect_stale();
    do_reset(4);
    run(3);
    n_checks++; if (iss_q.size() != 3) begin n_fail++; $display("FAIL rds_pre_issue got %0d want 3", iss_q.size()); end
    rv = 1'b1; rpc = 64'h1002;
    settle();
    n_checks++; if (fav !== 1'b0) begin n_fail++; $display("FAIL rds_fav_during got %b want 0", fav); end
    clk_edge();
    rv = 1'b0;
    clear_logs();
    n_checks++; if (fa !== 64'h1000) begin n_fail++; $display("FAIL rds_addr got %h want 1000", fa); end
    run(10);
    n_checks++; if (iss_q.size() == 0 || iss_q[0] !== 64'h1000) begin n_fail++; $display("FAIL rds_first_issue got %0d entries, want first 1000", iss_q.size()); end
    n_checks++; if (pop_pc.size() < 2) begin n_fail++; $display("FAIL rds_pop_count got %0d want >=2", pop_pc.size()); end
    if (pop_cyc.size() > 0) begin
      n_checks++; if (pop_cyc[0] != 9) begin n_fail++; $display("FAIL rds_first_pop_cycle got %0d want 9", pop_cyc[0]); end
    end
    for (int i = 0; i < pop_pc.size(); i++) begin
      n_checks++; if (pop_pc[i] !== 64'h1000 + 64'(4*i)) begin n_fail++; $display("FAIL rds_pc[%0d] got %h want %h", i, pop_pc[i], 64'h1000 + 64'(4*i)); end
      n_checks++; if (pop_data[i] !== mkdata(64'h1000 + 64'(4*i))) begin n_fail++; $display("FAIL rds_data[%0d] got %h want %h", i, pop_data[i], mkdata(64'h1000 + 64'(4*i))); end
    end
  endtask

  task automatic test_redirect_pop();
    do_reset(1);
    ir = 1'b0;
    run(3);
    n_checks++; if (occ !== 3'd2) begin n_fail++; $display("FAIL rdp_occ_before got %0d want 2", occ); end
    rv = 1'b1; rpc = 64'h2000; ir = 1'b1;
    settle();
    n_checks++; if (iv !== 1'b0) begin n_fail++; $display("FAIL rdp_iv_during got %b want 0", iv); end
    clk_edge();
    rv = 1'b0;
    n_checks++; if (pop_pc.size() != 0) begin n_fail++; $display("FAIL rdp_pop_suppressed got %0d pops want 0", pop_pc.size()); end
    n_checks++; if (occ !== 3'd0) begin n_fail++; $display("FAIL rdp_occ_after got %0d want 0", occ); end
    n_checks++; if (iv !== 1'b0) begin n_fail++; $display("FAIL rdp_iv_after got %b want 0", iv); end
    n_checks++; if (fa !== 64'h2000) begin n_fail++; $display("FAIL rdp_addr got %h want 2000", fa); end
    run(8);
    n_checks++; if (pop_pc.size() < 4) begin n_fail++; $display("FAIL rdp_pop_count got %0d want >=4", pop_pc.size()); end
    for (int i = 0; i < pop_pc.size(); i++) begin
      n_checks++; if (pop_pc[i] !== 64'h2000 + 64'(4*i)) begin n_fail++; $display("FAIL rdp_pc[%0d] got %h want %h", i, pop_pc[i], 64'h2000 + 64'(4*i)); end
      n_checks++; if (pop_data[i] !== mkdata(64'h2000 + 64'(4*i))) begin n_fail++; $display("FAIL rdp_data[%0d] got %h want %h", i, pop_data[i], mkdata(64'h2000 + 64'(4*i))); end
    end
  endtask

  task automatic test_pc_wrap();
    do_reset(1);
    #1;
    n_checks++; if (fav2 !== 1'b1) begin n_fail++; $display("FAIL wrap_fav got %b want 1", fav2); end
    n_checks++; if (fa2 !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr0 got %h want fffffffffffffffc", fa2); end
    run(1);
    n_checks++; if (fa2 !== 64'h0) begin n_fail++; $display("FAIL wrap_addr1 got %h want 0", fa2); end
    run(1);
    n_checks++; if (fa2 !== 64'h4) begin n_fail++; $display("FAIL wrap_addr2 got %h want 4", fa2); end
  endtask

  initial begin
    rstn = 1'b0; far = 1'b1; fdv = 1'b0; fd = 32'h0; rv = 1'b0; rpc = 64'h0; ir = 1'b1;
    far2 = 1'b1; fdv2 = 1'b0; fd2 = 32'h0; rv2 = 1'b0; rpc2 = 64'h0; ir2 = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_sequential();
    test_stall();
    test_toggle_ready();
    test_redirect_stale();
    test_redirect_pop();
    test_pc_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
